// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with a double-buffered value.
// Optional leading-zero blanking is enabled by defining SEG_LZB_EN.
module seg_scan_driver #(
   parameter int DIGITS   = 4,
   parameter int TICK_DIV = 50000,
   parameter int DIV_W    = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [4*DIGITS-1:0]   value,
   input  logic                  load,
   output logic [6:0]            seg,
   output logic [DIGITS-1:0]     an,
   output logic                  frame_done,
   output logic                  pending
);

   localparam int               DIG_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [DIV_W-1:0] PRSC_LAST = DIV_W'(TICK_DIV - 1);
   localparam logic [DIG_W-1:0] DIG_LAST  = DIG_W'(DIGITS - 1);

   logic [DIV_W-1:0]      prsc_q, prsc_d;
   logic [DIG_W-1:0]      dig_q, dig_d;
   logic [4*DIGITS-1:0]   shadow_q, shadow_d;
   logic [4*DIGITS-1:0]   disp_q, disp_d;
   logic                  pending_q, pending_d;
   logic [6:0]            seg_q, seg_d;
   logic [DIGITS-1:0]     an_q, an_d;
   logic                  tick;
   logic                  frameEnd;
   logic [3:0]            curNib;
`ifdef SEG_LZB_EN
   logic                  allZeroAbove;
   logic                  curBlank;
`endif

   function automatic logic [6:0] decodeHex(input logic [3:0] nib);
      logic [6:0] code;
      case (nib)
         4'h0:    code = 7'b1000000;
         4'h1:    code = 7'b1111001;
         4'h2:    code = 7'b0100100;
         4'h3:    code = 7'b0110000;
         4'h4:    code = 7'b0011001;
         4'h5:    code = 7'b0010010;
         4'h6:    code = 7'b0000010;
         4'h7:    code = 7'b1111000;
         4'h8:    code = 7'b0000000;
         4'h9:    code = 7'b0010000;
         4'hA:    code = 7'b0001000;
         4'hB:    code = 7'b0000011;
         4'hC:    code = 7'b1000110;
         4'hD:    code = 7'b0100001;
         4'hE:    code = 7'b0000110;
         default: code = 7'b0001110;
      endcase
      return code;
   endfunction

   // Scan timing: prescaler tick advances the digit; the last slot's tick ends a frame.
   always_comb begin
      tick     = (prsc_q == PRSC_LAST);
      frameEnd = tick && (dig_q == DIG_LAST);
      prsc_d   = tick ? '0 : prsc_q + DIV_W'(1);
      dig_d    = dig_q;
      if (tick) begin
         dig_d = (dig_q == DIG_LAST) ? '0 : dig_q + DIG_W'(1);
      end
   end

   // A load coinciding with a frame end still lets disp take the old shadow.
   always_comb begin
      shadow_d  = load ? value : shadow_q;
      disp_d    = frameEnd ? shadow_q : disp_q;
      pending_d = pending_q;
      if (load) begin
         pending_d = 1'b1;
      end else if (frameEnd) begin
         pending_d = 1'b0;
      end
   end

   always_comb begin
      curNib = '0;
      an_d   = '1;
`ifdef SEG_LZB_EN
      allZeroAbove = 1'b1;
      curBlank     = 1'b0;
`endif
      for (int i = DIGITS - 1; i >= 0; i--) begin
`ifdef SEG_LZB_EN
         allZeroAbove = allZeroAbove && (disp_q[4*i +: 4] == 4'h0);
`endif
         if (dig_q == DIG_W'(i)) begin
            curNib  = disp_q[4*i +: 4];
            an_d[i] = 1'b0;
`ifdef SEG_LZB_EN
            curBlank = (i > 0) && allZeroAbove;
`endif
         end
      end
`ifdef SEG_LZB_EN
      seg_d = curBlank ? 7'h7F : decodeHex(curNib);
`else
      seg_d = decodeHex(curNib);
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prsc_q    <= '0;
         dig_q     <= '0;
         shadow_q  <= '0;
         disp_q    <= '0;
         pending_q <= 1'b0;
         seg_q     <= 7'h7F;
         an_q      <= '1;
      end else begin
         prsc_q    <= prsc_d;
         dig_q     <= dig_d;
         shadow_q  <= shadow_d;
         disp_q    <= disp_d;
         pending_q <= pending_d;
         seg_q     <= seg_d;
         an_q      <= an_d;
      end
   end

   assign seg        = seg_q;
   assign an         = an_q;
   assign frame_done = frameEnd;
   assign pending    = pending_q;

endmodule
